// File: rtl/tdc_hit_arbiter_if.sv
// Hit-stream bundle between the per-channel TDC FIFOs, the hit arbiter and the packing datapath.
// The arbiter takes the master view: it accepts channel words and drives the merged stream.
interface tdc_hit_arbiter_if #(
    parameter int N_CH       = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int CW = $clog2(N_CH);

    logic [N_CH*DATA_WIDTH-1:0] s_data;
    logic [N_CH-1:0]            s_valid;
    logic [N_CH-1:0]            s_ready;
    logic [DATA_WIDTH-1:0]      m_data;
    logic [CW-1:0]              m_chan;
    logic                       m_valid;
    logic                       m_ready;

    modport master (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_chan, m_valid
    );

    modport slave (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_chan, m_valid
    );
endinterface

// File: rtl/tdc_hit_arbiter.sv
// Merges N_CH TDC hit streams into one registered stream tagged with the source channel,
// holding each grant for at most MAX_BURST words before re-arbitrating.
module tdc_hit_arbiter #(
    parameter int    N_CH         = 8,
    parameter int    DATA_WIDTH   = 32,
    parameter int    MAX_BURST    = 4,
    parameter string ARB_TYPE     = "ROUND_ROBIN",
    parameter string LSB_PRIORITY = "LOW",
    localparam int   CW           = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    tdc_hit_arbiter_if.master   hit,
    output logic                busy,
    output logic [CW-1:0]       grant_chan
);
    localparam int BW        = $clog2(MAX_BURST + 1);
    localparam bit IS_RR     = (ARB_TYPE == "ROUND_ROBIN");
    localparam bit LOW_FIRST = (LSB_PRIORITY == "HIGH");

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    logic [BW-1:0]         burst_cnt;
    logic [BW-1:0]         burst_inc;
    logic [N_CH-1:0]       rr_mask;
    logic [N_CH-1:0]       masked_req;
    logic [N_CH-1:0]       ready_vec;
    logic [CW-1:0]         next_chan;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  grant_valid;
    logic                  load_en;
    logic                  xfer;
    logic                  release_grant;

    // Team priority encoder: LSB_PRIORITY="HIGH" favours the lowest index, "LOW" the highest.
    function automatic logic [CW-1:0] prio_enc(input logic [N_CH-1:0] req);
        logic [CW-1:0] idx;
        idx = '0;
        if (LOW_FIRST) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (req[i]) idx = CW'(i);
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (req[i]) idx = CW'(i);
            end
        end
        return idx;
    endfunction

    // Channels still eligible in this round: those after the released one in priority order.
    function automatic logic [N_CH-1:0] mask_after(input logic [CW-1:0] g);
        logic [N_CH-1:0] m;
        for (int i = 0; i < N_CH; i++) begin
            m[i] = LOW_FIRST ? (i > int'(g)) : (i < int'(g));
        end
        return m;
    endfunction

    always_comb begin
        grant_valid = 1'b0;
        grant_data  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (i == int'(grant_chan)) begin
                grant_valid = hit.s_valid[i];
                grant_data  = hit.s_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign load_en = ~hit.m_valid | hit.m_ready;
    assign xfer    = (state == ACTIVE) & load_en & grant_valid;

    always_comb begin
        ready_vec = '0;
        if (state == ACTIVE && load_en) begin
            for (int i = 0; i < N_CH; i++) begin
                ready_vec[i] = (i == int'(grant_chan));
            end
        end
    end
    assign hit.s_ready = ready_vec;

    // An empty masked request wraps the round back to the full request vector.
    assign masked_req    = IS_RR ? (hit.s_valid & rr_mask) : '0;
    assign next_chan     = prio_enc((masked_req != '0) ? masked_req : hit.s_valid);
    assign burst_inc     = burst_cnt + BW'(1);
    assign release_grant = (state == ACTIVE) &
                           (~grant_valid | (xfer & (burst_inc == BW'(MAX_BURST))));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            grant_chan  <= '0;
            burst_cnt   <= '0;
            rr_mask     <= '0;
            hit.m_valid <= 1'b0;
            hit.m_data  <= '0;
            hit.m_chan  <= '0;
        end else begin
            if (xfer) begin
                hit.m_valid <= 1'b1;
                hit.m_data  <= grant_data;
                hit.m_chan  <= grant_chan;
            end else if (hit.m_ready) begin
                hit.m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hit.s_valid != '0) begin
                        grant_chan <= next_chan;
                        burst_cnt  <= '0;
                        busy       <= 1'b1;
                        state      <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (xfer) burst_cnt <= burst_inc;
                    if (release_grant) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (IS_RR) rr_mask <= mask_after(grant_chan);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tdc_hit_arbiter.sv
// Bench for tdc_hit_arbiter: three configurations share one stimulus, each checked every cycle
// against a channel-rotation model, plus literal expectations for the directed scenarios.
module tb_tdc_hit_arbiter;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int CW = 3;
    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic mready;

    logic [N*DW-1:0] sdata  [ND];
    logic [N-1:0]    svalid [ND];
    logic [N-1:0]    sready_w [ND];
    logic [DW-1:0]   mdata_w  [ND];
    logic [CW-1:0]   mchan_w  [ND];
    logic            mvalid_w [ND];
    logic            busy_w   [ND];
    logic [CW-1:0]   gch_w    [ND];

    tdc_hit_arbiter_if #(.N_CH(N), .DATA_WIDTH(DW)) bus0 ();
    tdc_hit_arbiter_if #(.N_CH(N), .DATA_WIDTH(DW)) bus1 ();
    tdc_hit_arbiter_if #(.N_CH(N), .DATA_WIDTH(DW)) bus2 ();

    assign bus0.s_data = sdata[0];  assign bus0.s_valid = svalid[0];  assign bus0.m_ready = mready;
    assign bus1.s_data = sdata[1];  assign bus1.s_valid = svalid[1];  assign bus1.m_ready = mready;
    assign bus2.s_data = sdata[2];  assign bus2.s_valid = svalid[2];  assign bus2.m_ready = mready;
    assign sready_w[0] = bus0.s_ready; assign mdata_w[0] = bus0.m_data;
    assign mchan_w[0]  = bus0.m_chan;  assign mvalid_w[0] = bus0.m_valid;
    assign sready_w[1] = bus1.s_ready; assign mdata_w[1] = bus1.m_data;
    assign mchan_w[1]  = bus1.m_chan;  assign mvalid_w[1] = bus1.m_valid;
    assign sready_w[2] = bus2.s_ready; assign mdata_w[2] = bus2.m_data;
    assign mchan_w[2]  = bus2.m_chan;  assign mvalid_w[2] = bus2.m_valid;

    tdc_hit_arbiter #(.N_CH(N), .DATA_WIDTH(DW), .MAX_BURST(4),
                      .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("HIGH")) dut0 (
        .clk(clk), .rst(rst), .hit(bus0), .busy(busy_w[0]), .grant_chan(gch_w[0]));
    tdc_hit_arbiter #(.N_CH(N), .DATA_WIDTH(DW), .MAX_BURST(1),
                      .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("HIGH")) dut1 (
        .clk(clk), .rst(rst), .hit(bus1), .busy(busy_w[1]), .grant_chan(gch_w[1]));
    tdc_hit_arbiter #(.N_CH(N), .DATA_WIDTH(DW), .MAX_BURST(4),
                      .ARB_TYPE("PRIORITY"), .LSB_PRIORITY("LOW")) dut2 (
        .clk(clk), .rst(rst), .hit(bus2), .busy(busy_w[2]), .grant_chan(gch_w[2]));

    function automatic int cfg_mb(int d);   return (d == 1) ? 1 : 4; endfunction
    function automatic bit cfg_rr(int d);   return d != 2;           endfunction
    function automatic bit cfg_high(int d); return d != 2;           endfunction

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Channel sources behave as FIFOs: word = base + number already accepted.
    int          base [N];
    int          limit [N];
    int          popped [ND][N];
    logic [N-1:0] pop [ND];

    task automatic update_inputs();
        for (int d = 0; d < ND; d++)
            for (int ch = 0; ch < N; ch++) begin
                svalid[d][ch]         = (popped[d][ch] < limit[ch]);
                sdata[d][ch*DW +: DW] = DW'(base[ch] + popped[d][ch]);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++)
            for (int ch = 0; ch < N; ch++)
                if (pop[d][ch]) popped[d][ch]++;
        update_inputs();
    endtask

    // Model: who holds the grant, burst count, last released channel, output register.
    bit            mb_busy [ND];
    int            mg [ND];
    int            mcnt [ND];
    int            mlast [ND];
    bit            mov [ND];
    logic [DW-1:0] mod_d [ND];
    int            moc [ND];

    task automatic model_reset(input int d);
        mb_busy[d] = 1'b0; mg[d] = 0; mcnt[d] = 0; mov[d] = 1'b0; mod_d[d] = '0; moc[d] = 0;
        mlast[d] = cfg_high(d) ? -1 : N;
    endtask

    // Scan channels in rotation order starting just past the last released one.
    function automatic int pick(int d, logic [N-1:0] req);
        int anchor, c;
        anchor = cfg_rr(d) ? mlast[d] : (cfg_high(d) ? -1 : N);
        for (int k = 0; k < N; k++) begin
            if (cfg_high(d)) c = (anchor + 1 + k) % N;
            else             c = ((anchor - 1 - k) % N + N) % N;
            if (req[c]) return c;
        end
        return 0;
    endfunction

    int            cyc = 0;
    logic          tv [64];
    logic          tbz [64];
    logic [CW-1:0] tg [64];
    logic [N-1:0]  ts [64];
    logic [DW-1:0] td [64];
    int            ln [ND];
    logic [CW-1:0] lch [ND][64];
    logic [DW-1:0] ldat [ND][64];
    int            lcyc [ND][64];

    initial begin
        for (int d = 0; d < ND; d++) begin
            model_reset(d);
            pop[d] = '0;
            ln[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                logic [N-1:0] er;
                bit gv, x;
                er = '0;
                if (mb_busy[d] && (!mov[d] || mready)) er[mg[d]] = 1'b1;
                chk($sformatf("d%0d_m_valid", d), 64'(mvalid_w[d]), 64'(mov[d]));
                chk($sformatf("d%0d_m_data", d), 64'(mdata_w[d]), 64'(mod_d[d]));
                chk($sformatf("d%0d_m_chan", d), 64'(mchan_w[d]), 64'(moc[d]));
                chk($sformatf("d%0d_busy", d), 64'(busy_w[d]), 64'(mb_busy[d]));
                chk($sformatf("d%0d_grant_chan", d), 64'(gch_w[d]), 64'(mg[d]));
                chk($sformatf("d%0d_s_ready", d), 64'(sready_w[d]), 64'(er));

                if (mvalid_w[d] && mready && ln[d] < 64) begin
                    lch[d][ln[d]] = mchan_w[d];
                    ldat[d][ln[d]] = mdata_w[d];
                    lcyc[d][ln[d]] = cyc;
                    ln[d]++;
                end
                pop[d] = svalid[d] & sready_w[d];

                if (rst) begin
                    model_reset(d);
                end else begin
                    gv = svalid[d][mg[d]];
                    x  = mb_busy[d] && (!mov[d] || mready) && gv;
                    if (x) begin
                        mov[d] = 1'b1;
                        mod_d[d] = sdata[d][mg[d]*DW +: DW];
                        moc[d] = mg[d];
                    end else if (mready) begin
                        mov[d] = 1'b0;
                    end
                    if (!mb_busy[d]) begin
                        if (svalid[d] != '0) begin
                            mg[d] = pick(d, svalid[d]);
                            mcnt[d] = 0;
                            mb_busy[d] = 1'b1;
                        end
                    end else if (!gv) begin
                        mb_busy[d] = 1'b0;
                        mlast[d] = mg[d];
                    end else if (x) begin
                        mcnt[d]++;
                        if (mcnt[d] == cfg_mb(d)) begin
                            mb_busy[d] = 1'b0;
                            mlast[d] = mg[d];
                        end
                    end
                end
            end
            if (cyc < 64) begin
                tv[cyc] = mvalid_w[0]; tbz[cyc] = busy_w[0]; tg[cyc] = gch_w[0];
                ts[cyc] = sready_w[0]; td[cyc] = mdata_w[0];
            end
            cyc++;
        end
    end

    task automatic start_scen();
        rst = 1'b1;
        mready = 1'b1;
        for (int ch = 0; ch < N; ch++) begin base[ch] = 0; limit[ch] = 0; end
        update_inputs();
        tick();
        tick();
        rst = 1'b0;
        for (int d = 0; d < ND; d++) begin
            for (int ch = 0; ch < N; ch++) popped[d][ch] = 0;
            ln[d] = 0;
        end
    endtask

    task automatic begin_scen();
        update_inputs();
        cyc = 0;
    endtask

    int            t2c [6] = '{0, 2, 5, 0, 2, 5};
    logic [DW-1:0] t5d [5] = '{32'h400, 32'h401, 32'h700, 32'h701, 32'h702};
    logic [9:0]    vp;
    logic [4:0]    bp;

    initial begin
        rst = 1'b1;
        mready = 1'b1;
        for (int d = 0; d < ND; d++)
            for (int ch = 0; ch < N; ch++) popped[d][ch] = 0;
        for (int ch = 0; ch < N; ch++) begin base[ch] = 0; limit[ch] = 0; end
        update_inputs();

        // Single channel 3, six words, bursts of four.
        start_scen();
        base[3] = 32'hA0; limit[3] = 6;
        begin_scen();
        repeat (14) tick();
        chk("reset_m_valid", 64'(tv[0]), 64'd0);
        chk("reset_busy", 64'(tbz[0]), 64'd0);
        chk("reset_s_ready", 64'(ts[0]), 64'd0);
        chk("reset_grant_chan", 64'(tg[0]), 64'd0);
        chk("reset_m_data", 64'(td[0]), 64'd0);
        for (int k = 0; k < 10; k++) vp[k] = tv[k];
        chk("single_valid_pattern", 64'(vp), 64'(10'b0110111100));
        chk("single_latency", 64'(lcyc[0][0]), 64'd2);
        chk("single_words", 64'(ln[0]), 64'd6);
        for (int k = 0; k < 6; k++) begin
            chk("single_chan", 64'(lch[0][k]), 64'd3);
            chk("single_data", 64'(ldat[0][k]), 64'(32'hA0 + k));
        end

        // Round robin over channels 0, 2, 5 with one word per grant.
        start_scen();
        base[0] = 32'h000; base[2] = 32'h200; base[5] = 32'h500;
        limit[0] = 100; limit[2] = 100; limit[5] = 100;
        begin_scen();
        repeat (16) tick();
        chk("rr_enough_words", 64'(ln[1] >= 6), 64'd1);
        for (int k = 0; k < 6; k++) begin
            chk("rr_chan", 64'(lch[1][k]), 64'(t2c[k]));
            chk("rr_data", 64'(ldat[1][k]), 64'(t2c[k] * 256 + k / 3));
        end
        for (int k = 0; k < ln[1] - 1; k++)
            chk("rr_no_repeat", 64'(lch[1][k] != lch[1][k+1]), 64'd1);

        // Fixed priority: channel 6 always beats channel 1.
        start_scen();
        base[1] = 32'h100; base[6] = 32'h600;
        limit[1] = 100; limit[6] = 100;
        begin_scen();
        repeat (20) tick();
        chk("prio_words", 64'(ln[2]), 64'd15);
        for (int k = 0; k < ln[2]; k++) begin
            chk("prio_chan", 64'(lch[2][k]), 64'd6);
            chk("prio_data", 64'(ldat[2][k]), 64'(32'h600 + k));
        end

        // Backpressure for five cycles in the middle of a channel 2 burst.
        start_scen();
        base[2] = 32'h200; limit[2] = 6;
        begin_scen();
        repeat (3) tick();
        mready = 1'b0;
        repeat (5) tick();
        mready = 1'b1;
        repeat (12) tick();
        for (int k = 3; k <= 7; k++) begin
            chk("stall_m_data", 64'(td[k]), 64'h201);
            chk("stall_m_valid", 64'(tv[k]), 64'd1);
            chk("stall_s_ready", 64'(ts[k]), 64'd0);
        end
        chk("stall_words", 64'(ln[0]), 64'd6);
        for (int k = 0; k < 6; k++) chk("stall_data", 64'(ldat[0][k]), 64'(32'h200 + k));
        chk("stall_burst_gap", 64'(lcyc[0][4] - lcyc[0][3]), 64'd2);
        chk("stall_in_burst", 64'(lcyc[0][3] - lcyc[0][2]), 64'd1);

        // Early release of channel 4 after two words; channel 7 waiting.
        start_scen();
        base[4] = 32'h400; limit[4] = 2;
        base[7] = 32'h700; limit[7] = 3;
        begin_scen();
        repeat (12) tick();
        for (int k = 0; k < 5; k++) bp[k] = tbz[k+1];
        chk("early_busy_pattern", 64'(bp), 64'(5'b10111));
        chk("early_first_grant", 64'(tg[1]), 64'd4);
        chk("early_next_grant", 64'(tg[5]), 64'd7);
        chk("early_words", 64'(ln[0]), 64'd5);
        for (int k = 0; k < 5; k++) chk("early_data", 64'(ldat[0][k]), 64'(t5d[k]));

        // Reset during the channel 5 burst; arbitration restarts as if the mask were clear.
        start_scen();
        base[1] = 32'h100; base[5] = 32'h500;
        limit[1] = 100; limit[5] = 100;
        begin_scen();
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("midrst_pre_grant", 64'(tg[7]), 64'd5);
        chk("midrst_pre_valid", 64'(tv[7]), 64'd1);
        chk("midrst_pre_busy", 64'(tbz[7]), 64'd1);
        chk("midrst_m_valid", 64'(tv[8]), 64'd0);
        chk("midrst_busy", 64'(tbz[8]), 64'd0);
        chk("midrst_s_ready", 64'(ts[8]), 64'd0);
        chk("midrst_regrant_busy", 64'(tbz[9]), 64'd1);
        chk("midrst_regrant_chan", 64'(tg[9]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tdc_hit_arbiter.md
Name: tdc_hit_arbiter

Overview:
- Round-robin/fixed-priority arbiter that merges N_CH per-channel TDC hit streams (valid/ready) into one registered output stream, tagging each word with its source channel.
- Sits between the per-channel TDC deserialiser FIFOs and the shared hit-packing datapath.
- Grant selection uses the team's priority encoder.
- Holds a grant for up to MAX_BURST words, then re-arbitrates.

Parameters:
- N_CH, 8, number of request channels (≥2).
- DATA_WIDTH, 32, hit word width.
- MAX_BURST, 4, maximum consecutive words per grant (≥1).
- ARB_TYPE, "ROUND_ROBIN", "ROUND_ROBIN" or "PRIORITY".
- LSB_PRIORITY, "LOW", "LOW": highest index wins fixed priority; "HIGH": lowest index wins.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_data  in  N_CH*DATA_WIDTH  channel i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_valid  in  N_CH  per-channel word available.
- s_ready  out  N_CH  per-channel word accepted this cycle.
- m_data  out  DATA_WIDTH  output word.
- m_chan  out  $clog2(N_CH)  source channel of m_data.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- busy  out  1  grant active (state ACTIVE).
- grant_chan  out  $clog2(N_CH)  currently/last granted channel.

Behaviour:
- Reset: all outputs and state are cleared.
  - State becomes IDLE; m_valid, busy, s_ready, m_data, m_chan, grant_chan, burst counter and RR mask all go to 0.
  - Any word held in the output register is discarded.
- Load enable: load_en = ~m_valid | m_ready.
- Ready: s_ready[i] = (state==ACTIVE) & (i==grant_chan) & load_en. This is combinational; at most one bit is set.
- Transfer: s_valid[i] & s_ready[i]. On the next edge, m_data/m_chan are loaded and m_valid=1.
- Output hold: if m_ready=1 and no transfer occurs, m_valid clears on the next edge. If m_ready=0, m_data/m_chan/m_valid hold stable.
- FSM IDLE:
  - Arbitration uses req = s_valid. For ROUND_ROBIN, masked req = req & mask; if the masked req is nonzero it is encoded, else the unmasked req.
  - For PRIORITY, mask is ignored.
  - If req≠0: register grant_chan, clear the burst counter, go to ACTIVE. No transfer occurs in IDLE.
- FSM ACTIVE:
  - Each transfer increments the burst counter.
  - Release to IDLE when a transfer brings the count to MAX_BURST, or when s_valid[grant_chan]=0 (checked every cycle, including while stalled).
  - On release with ROUND_ROBIN, the mask is updated:
    - LSB_PRIORITY="HIGH": mask = bits strictly above grant_chan.
    - LSB_PRIORITY="LOW": mask = bits strictly below grant_chan.
- Latency: request in IDLE at cycle 0 with empty output → grant at edge 1, transfer in cycle 1, m_valid high after edge 2.
- Throughput: one word/cycle within a burst; exactly one idle-arbitration cycle between grants.
- Stall: with m_ready=0 and m_valid=1, no transfer occurs and the burst counter freezes; the grant is held unless s_valid drops.
- Simultaneous events:
  - Release and new request in the same cycle: the new grant is decided in the following IDLE cycle using the updated mask.
  - Transfer and m_ready in the same cycle: the old word is consumed and the new word is loaded (no bubble).
- Widths: the burst counter is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST. The mask is N_CH bits. Wrap-around is implicit: an all-zero masked req falls back to the unmasked req.
- Reset mid-burst: returns to IDLE on the next edge. The first post-reset arbitration is equivalent to mask=0.

Test Plan:
- Single channel: s_valid[3]=1 with words 0xA0..0xA5, m_ready=1, MAX_BURST=4 → m_chan=3 outputs 0xA0–0xA3, one bubble, then 0xA4–0xA5. First m_valid occurs 2 cycles after s_valid.
- Round robin: channels 0, 2, 5 continuously valid, LSB_PRIORITY="HIGH", MAX_BURST=1 → m_chan sequence 0, 2, 5, 0, 2, 5; no channel is granted twice consecutively.
- Fixed priority: ARB_TYPE="PRIORITY", LSB_PRIORITY="LOW", channels 1 and 6 always valid → only channel 6 is ever granted.
- Backpressure: during a burst on channel 2, m_ready=0 for 5 cycles.
  - m_data stays stable and s_ready[2]=0 throughout.
  - The burst counter freezes.
  - After release: no word is lost or duplicated, and the count still totals 4.
- Early release: channel 4 deasserts s_valid after 2 words (MAX_BURST=4) → busy falls the next cycle and channel 7, pending, is granted after one IDLE cycle.
- Reset mid-operation: assert rst while m_valid=1 in ACTIVE → the next cycle shows m_valid=0, busy=0, s_ready=0. After release, arbitration restarts from mask=0.
